// File: rtl/frame_sequencer_if.sv
// Handshake bundle between the frame sequencer and its surroundings
// (frame pulse, feeder/renderer handshakes, status and stats).
interface frame_sequencer_if;
  logic        frame_start;
  logic        feeder_valid;
  logic        renderer_ready;
  logic        renderer_busy;
  logic        cam_valid;
  logic        feeder_begin;
  logic        first_tri;
  logic        swap;
  logic        busy;
  logic [15:0] tri_count;
  logic        timeout_err;
  logic [15:0] frames_rendered;
  logic [15:0] frames_dropped;

  modport slave (
    input  frame_start, feeder_valid, renderer_ready, renderer_busy,
    output cam_valid, feeder_begin, first_tri, swap, busy, tri_count,
           timeout_err, frames_rendered, frames_dropped
  );

  modport master (
    output frame_start, feeder_valid, renderer_ready, renderer_busy,
    input  cam_valid, feeder_begin, first_tri, swap, busy, tri_count,
           timeout_err, frames_rendered, frames_dropped
  );
endinterface

// File: rtl/frame_sequencer.sv
// Per-frame sequencer: camera request, triangle feed, drain, buffer swap, with watchdog.
// Define FRAME_SEQUENCER_STATS_EN to build the frames_rendered/frames_dropped counters.
module frame_sequencer #(
  parameter int unsigned N_TRIS         = 712,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic              clk,
  input  logic              rst,
  frame_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CAM, FEED, DRAIN, SWAP} state_t;

  localparam logic [15:0] TRI_LAST = 16'(N_TRIS - 1);
  localparam logic [23:0] WD_LAST  = 24'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [23:0] wd;
  logic        cam_valid_q, feeder_begin_q, first_tri_q, swap_q, busy_q, timeout_err_q;
  logic [15:0] tri_count_q;
  logic        handshake, wd_expire;

  assign handshake = bus.feeder_valid && bus.renderer_ready;
  // Fires on the edge where the watchdog would reach the limit.
  assign wd_expire = (state == FEED || state == DRAIN) && (wd == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wd             <= '0;
      cam_valid_q    <= 1'b0;
      feeder_begin_q <= 1'b0;
      first_tri_q    <= 1'b0;
      swap_q         <= 1'b0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      tri_count_q    <= '0;
    end else begin
      cam_valid_q    <= 1'b0;
      feeder_begin_q <= 1'b0;
      swap_q         <= 1'b0;
      case (state)
        IDLE: if (bus.frame_start) begin
          state       <= CAM;
          cam_valid_q <= 1'b1;
          busy_q      <= 1'b1;
          tri_count_q <= '0;
        end
        CAM: begin
          state          <= FEED;
          feeder_begin_q <= 1'b1;
          first_tri_q    <= 1'b1;
          wd             <= '0;
        end
        FEED: begin
          wd <= wd + 24'd1;
          if (wd_expire) begin
            state         <= IDLE;
            busy_q        <= 1'b0;
            first_tri_q   <= 1'b0;
            timeout_err_q <= 1'b1;
          end else if (handshake) begin
            tri_count_q <= tri_count_q + 16'd1;
            first_tri_q <= 1'b0;
            if (tri_count_q == TRI_LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          wd <= wd + 24'd1;
          if (wd_expire) begin
            state         <= IDLE;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
          end else if (!bus.renderer_busy) begin
            state  <= SWAP;
            swap_q <= 1'b1;
          end
        end
        SWAP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cam_valid    = cam_valid_q;
  assign bus.feeder_begin = feeder_begin_q;
  assign bus.first_tri    = first_tri_q;
  assign bus.swap         = swap_q;
  assign bus.busy         = busy_q;
  assign bus.tri_count    = tri_count_q;
  assign bus.timeout_err  = timeout_err_q;

`ifdef FRAME_SEQUENCER_STATS_EN
  logic [15:0] frames_rendered_q, frames_dropped_q;

  // Any frame_start outside IDLE is a rejected frame; both counters saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames_rendered_q <= '0;
      frames_dropped_q  <= '0;
    end else begin
      if (state == SWAP && frames_rendered_q != 16'hFFFF)
        frames_rendered_q <= frames_rendered_q + 16'd1;
      if (bus.frame_start && state != IDLE && frames_dropped_q != 16'hFFFF)
        frames_dropped_q <= frames_dropped_q + 16'd1;
    end
  end

  assign bus.frames_rendered = frames_rendered_q;
  assign bus.frames_dropped  = frames_dropped_q;
`else
  assign bus.frames_rendered = 16'h0;
  assign bus.frames_dropped  = 16'h0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: vector table for the nominal frame, then frame-level
// reference model driven by directed and random per-slot input arrays.
module tb_frame_sequencer;
  localparam int NT  = 4;
  localparam int TO  = 100;
  localparam int LEN = 200;
`ifdef FRAME_SEQUENCER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_sequencer_if bus();
  frame_sequencer #(.N_TRIS(NT), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int exp_rendered = 0, exp_dropped = 0;
  bit exp_to = 1'b0;

  bit a_fs[LEN], a_fv[LEN], a_rr[LEN], a_rb[LEN];

  typedef struct packed {
    logic fs, fv, rr, rb;
    logic cam, fb, ft, sw, bsy;
    logic [15:0] tc;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Apply inputs for one slot, let the edge take them, look at outputs on the falling edge.
  task automatic drive(input bit fs, input bit fv, input bit rr, input bit rb);
    bus.frame_start = fs; bus.feeder_valid = fv; bus.renderer_ready = rr; bus.renderer_busy = rb;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, " frames_rendered"}, bus.frames_rendered, STATS ? exp_rendered : 0);
    chk({tag, " frames_dropped"},  bus.frames_dropped,  STATS ? exp_dropped  : 0);
  endtask

  task automatic clear_frame();
    for (int i = 0; i < LEN; i++) begin a_fs[i] = 0; a_fv[i] = 0; a_rr[i] = 0; a_rb[i] = 0; end
    a_fs[0] = 1;
  endtask

  // Frame-level model: slot 0 carries frame_start, FEED covers slots from 2 on, the
  // N-th handshake at slot h opens DRAIN, first idle renderer slot d>h swaps unless
  // the watchdog limit (edge of slot TO+1) comes first.
  task automatic run_frame(input string tag, output int sw_at);
    int h, h1, d, e, cnt, drops, bad_pulse, bad_ft, bad_sw, bad_busy;
    bit swapped, exp_ft;
    h = -1; h1 = -1; cnt = 0; d = -1;
    for (int i = 2; i < LEN; i++)
      if (a_fv[i] && a_rr[i]) begin
        if (h1 < 0) h1 = i;
        cnt++;
        if (cnt == NT) begin h = i; break; end
      end
    if (h >= 0)
      for (int i = h + 1; i < LEN; i++)
        if (!a_rb[i]) begin d = i; break; end
    swapped = (d >= 0) && (d <= TO);
    e = swapped ? d + 1 : TO + 1;
    drops = 0;
    for (int i = 1; i <= e; i++) drops += int'(a_fs[i]);
    sw_at = -1; bad_pulse = 0; bad_ft = 0; bad_sw = 0; bad_busy = 0;
    for (int i = 0; i <= e; i++) begin
      drive(a_fs[i], a_fv[i], a_rr[i], a_rb[i]);
      exp_ft = (i >= 1) && (i < e) && (h1 < 0 || i < h1);
      if (bus.cam_valid !== (i == 0)) bad_pulse++;
      if (bus.feeder_begin !== (i == 1)) bad_pulse++;
      if (i == 0 && bus.tri_count !== 16'd0) bad_pulse++;
      if (bus.first_tri !== exp_ft) bad_ft++;
      if (bus.busy !== (i < e)) bad_busy++;
      if (bus.swap === 1'b1 && sw_at < 0) sw_at = i;
      if (bus.swap !== (swapped && i == d)) bad_sw++;
    end
    chk({tag, " cam/begin pulses"}, bad_pulse, 0);
    chk({tag, " first_tri slots"}, bad_ft, 0);
    chk({tag, " busy slots"}, bad_busy, 0);
    chk({tag, " swap slots"}, bad_sw, 0);
    if (swapped) chk({tag, " tri_count"}, bus.tri_count, NT);
    exp_to = exp_to | !swapped;
    chk({tag, " timeout_err"}, bus.timeout_err, exp_to);
    exp_rendered += int'(swapped);
    exp_dropped  += drops;
    chk_stats(tag);
  endtask

  initial begin
    int sw_at, pv, pr, pb;
    bus.frame_start = 0; bus.feeder_valid = 0; bus.renderer_ready = 0; bus.renderer_busy = 0;
    repeat (2) @(negedge clk);
    chk("reset busy", bus.busy, 0);
    chk("reset ctl", {bus.cam_valid, bus.feeder_begin, bus.first_tri, bus.swap, bus.timeout_err}, 0);
    chk("reset tri_count", bus.tri_count, 0);
    chk_stats("reset");
    rst = 1'b0;

    // Nominal frame, frame_start at cycle 10.
    tbl[0] = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1, 16'd0};
    tbl[1] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b1, 16'd0};
    tbl[2] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1, 16'd1};
    tbl[3] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1, 16'd2};
    tbl[4] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1, 16'd3};
    tbl[5] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1, 16'd4};
    tbl[6] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1, 16'd4};
    tbl[7] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 16'd4};
    tbl[8] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 16'd4};
    for (int i = 0; i < 8; i++) drive(0, 1, 1, 0);
    chk("idle ignores handshakes", {bus.busy, bus.tri_count}, 0);
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].fs, tbl[i].fv, tbl[i].rr, tbl[i].rb);
      chk($sformatf("vec%0d ctl", i),
          {bus.cam_valid, bus.feeder_begin, bus.first_tri, bus.swap, bus.busy},
          {tbl[i].cam, tbl[i].fb, tbl[i].ft, tbl[i].sw, tbl[i].bsy});
      chk($sformatf("vec%0d tri_count", i), bus.tri_count, tbl[i].tc);
    end
    exp_rendered = 1;
    chk_stats("vec");

    // Ready toggling: handshakes at slots 2,4,6,8 -> swap right after edge 9.
    clear_frame();
    for (int i = 1; i < LEN; i++) begin a_fv[i] = 1; a_rr[i] = (i % 2 == 0); end
    run_frame("toggle", sw_at);
    chk("toggle swap slot", sw_at, 9);

    // Renderer busy for 50 slots after DRAIN entry (slot 6) -> swap after edge 56.
    clear_frame();
    for (int i = 1; i < LEN; i++) begin a_fv[i] = 1; a_rr[i] = 1; a_rb[i] = (i >= 6 && i < 56); end
    run_frame("busy50", sw_at);
    chk("busy50 swap slot", sw_at, 56);

    // frame_start during FEED (slot 3) and during the SWAP cycle (slot 7).
    clear_frame();
    for (int i = 1; i < LEN; i++) begin a_fv[i] = 1; a_rr[i] = 1; end
    a_fs[3] = 1; a_fs[7] = 1;
    run_frame("drops", sw_at);
    chk("drops swap slot", sw_at, 6);
    chk("drops count", bus.frames_dropped, STATS ? 2 : 0);

    // Feeder stuck: watchdog ends the frame, next frame must still run.
    clear_frame();
    run_frame("timeout", sw_at);
    chk("timeout no swap", sw_at, -1);
    clear_frame();
    for (int i = 1; i < LEN; i++) begin a_fv[i] = 1; a_rr[i] = 1; end
    run_frame("after-timeout", sw_at);
    chk("after-timeout swap slot", sw_at, 6);

    for (int f = 0; f < 25; f++) begin
      pv = $urandom_range(1, 10); pr = $urandom_range(2, 10); pb = $urandom_range(0, 8);
      clear_frame();
      for (int i = 1; i < LEN; i++) begin
        a_fs[i] = ($urandom_range(0, 19) == 0);
        a_fv[i] = ($urandom_range(0, 9) < pv);
        a_rr[i] = ($urandom_range(0, 9) < pr);
        a_rb[i] = ($urandom_range(0, 9) < pb);
      end
      run_frame($sformatf("rnd%0d", f), sw_at);
      repeat ($urandom_range(0, 3)) drive(0, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Reset in the middle of FEED, two triangles in.
    drive(1, 1, 1, 0); drive(0, 1, 1, 0); drive(0, 1, 1, 0); drive(0, 1, 1, 0);
    chk("midfeed tri_count", bus.tri_count, 2);
    rst = 1'b1;
    #1;
    chk("async rst busy", bus.busy, 0);
    chk("async rst tri_count", bus.tri_count, 0);
    chk("async rst timeout_err", bus.timeout_err, 0);
    exp_to = 0; exp_rendered = 0; exp_dropped = 0;
    chk_stats("async rst");
    @(negedge clk);
    rst = 1'b0;
    clear_frame();
    for (int i = 1; i < LEN; i++) begin a_fv[i] = 1; a_rr[i] = 1; end
    run_frame("post-reset", sw_at);
    chk("post-reset swap slot", sw_at, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
